// File: rtl/ifetch_unit_pkg.sv
// Shared constants and the fetch state encoding for the instruction-fetch stage.
package ifetch_unit_pkg;

  localparam int unsigned DefWord  = 64;
  localparam int unsigned DefInstr = 32;
  localparam int unsigned PcInc    = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHold  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifetch_unit_branch_target.sv
// Branch resolution: redirect decision and target address from memory-stage branch info.
module ifetch_unit_branch_target
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned WORD = DefWord
) (
  input  logic            branch,
  input  logic            uncondbranch,
  input  logic            zero,
  input  logic [WORD-1:0] branch_pc,
  input  logic [WORD-1:0] branch_offset,
  output logic            pc_src,
  output logic [WORD-1:0] target
);

  // Offset counts instruction words; the sum wraps silently at WORD bits.
  always_comb begin
    pc_src = uncondbranch | (branch & zero);
    target = branch_pc + (branch_offset << 2);
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory and feeds the IF/ID register.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned      WORD     = DefWord,
  parameter int unsigned      INSTR    = DefInstr,
  parameter logic [WORD-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [WORD-1:0]   imem_addr,
  output logic              imem_req,
  input  logic [INSTR-1:0]  imem_data,
  input  logic              imem_ready,
  input  logic              branch,
  input  logic              uncondbranch,
  input  logic              zero,
  input  logic [WORD-1:0]   branch_pc,
  input  logic [WORD-1:0]   branch_offset,
  output logic              pc_src,
  input  logic              id_stall,
  output logic [INSTR-1:0]  if_instr,
  output logic [WORD-1:0]   if_pc,
  output logic              if_valid
);

  fetch_state_e     state_q, state_d;
  logic [WORD-1:0]  pc_q, pc_d;
  logic [INSTR-1:0] hold_q, hold_d;
  logic [INSTR-1:0] if_instr_q, if_instr_d;
  logic [WORD-1:0]  if_pc_q, if_pc_d;
  logic             if_valid_q, if_valid_d;
  logic [WORD-1:0]  target;
  logic             slot_free;

  ifetch_unit_branch_target #(
    .WORD (WORD)
  ) u_branch_target (
    .branch        (branch),
    .uncondbranch  (uncondbranch),
    .zero          (zero),
    .branch_pc     (branch_pc),
    .branch_offset (branch_offset),
    .pc_src        (pc_src),
    .target        (target)
  );

  assign slot_free = ~if_valid_q | ~id_stall;
  assign imem_addr = pc_q;
  assign imem_req  = (state_q == StFetch);
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign if_valid  = if_valid_q;

  // Next-state for PC, fetch FSM, hold buffer and IF/ID; redirect applied last so it wins.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_d     = hold_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;

    case (state_q)
      StIdle: begin
        state_d = StFetch;
      end
      StFetch: begin
        if (imem_ready && slot_free) begin
          if_instr_d = imem_data;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + WORD'(PcInc);
        end else if (imem_ready) begin
          // Decode is full: park the word and stop requesting until it drains.
          hold_d  = imem_data;
          state_d = StHold;
        end else if (!id_stall) begin
          if_valid_d = 1'b0;
        end
      end
      StHold: begin
        if (!id_stall) begin
          if_instr_d = hold_q;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + WORD'(PcInc);
          state_d    = StFetch;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (pc_src) begin
      pc_d    = target;
      state_d = StFetch;
      // Any data returned this cycle is wrong-path; payload fields keep their old contents.
      if_instr_d = if_instr_q;
      if_pc_d    = if_pc_q;
      if (state_q != StIdle) begin
        if_valid_d = 1'b0;
        hold_d     = '0;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      hold_q     <= '0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      hold_q     <= hold_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: reset, streaming, stall/hold, redirects, wrap, async reset.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_data;
  logic        imem_ready;
  logic        branch;
  logic        uncondbranch;
  logic        zero;
  logic [63:0] branch_pc;
  logic [63:0] branch_offset;
  logic        pc_src;
  logic        id_stall;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        if_valid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h8B02_0020;
    return a[31:0] ^ 32'h9100_0000;
  endfunction

  assign imem_data = mem_word(imem_addr);

  ifetch_unit #(
    .WORD     (64),
    .INSTR    (32),
    .RESET_PC (64'h0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_req      (imem_req),
    .imem_data     (imem_data),
    .imem_ready    (imem_ready),
    .branch        (branch),
    .uncondbranch  (uncondbranch),
    .zero          (zero),
    .branch_pc     (branch_pc),
    .branch_offset (branch_offset),
    .pc_src        (pc_src),
    .id_stall      (id_stall),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_valid      (if_valid)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; returns at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b1; id_stall = 1'b0;
    branch = 1'b0; uncondbranch = 1'b0; zero = 1'b0;
    branch_pc = '0; branch_offset = '0;
    repeat (2) step();

    // 1: reset values, then streaming fetch
    chk("rst_req", imem_req, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_instr", if_instr, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_addr", imem_addr, 0);
    rst_n = 1'b1;
    #1 chk("idle_req", imem_req, 0);
    step();
    chk("f0_req", imem_req, 1);
    chk("f0_addr", imem_addr, 64'h0);
    chk("f0_valid", if_valid, 0);
    step();
    chk("f1_valid", if_valid, 1);
    chk("f1_ifpc", if_pc, 64'h0);
    chk("f1_instr", if_instr, 64'h8B02_0020);
    chk("f1_addr", imem_addr, 64'h4);
    step();
    chk("f2_ifpc", if_pc, 64'h4);
    chk("f2_instr", if_instr, 64'h9100_0004);
    chk("f2_addr", imem_addr, 64'h8);
    step();
    step();
    chk("f4_addr", imem_addr, 64'h10);
    chk("f4_ifpc", if_pc, 64'hC);

    // 2: stall while full -> HOLD, then drain
    id_stall = 1'b1;
    step();
    chk("hold_req", imem_req, 0);
    chk("hold_addr", imem_addr, 64'h10);
    chk("hold_ifpc", if_pc, 64'hC);
    chk("hold_valid", if_valid, 1);
    step();
    chk("hold2_req", imem_req, 0);
    chk("hold2_addr", imem_addr, 64'h10);
    id_stall = 1'b0;
    step();
    chk("drain_ifpc", if_pc, 64'h10);
    chk("drain_instr", if_instr, 64'h9100_0010);
    chk("drain_addr", imem_addr, 64'h14);
    chk("drain_req", imem_req, 1);

    // 3: conditional branch taken (data at 0x14 dropped), then not taken
    branch = 1'b1; zero = 1'b1; branch_pc = 64'h20; branch_offset = 64'hFFFF_FFFF_FFFF_FFFE;
    #1 chk("bc_pcsrc", pc_src, 1);
    step();
    branch = 1'b0; zero = 1'b0;
    chk("bc_addr", imem_addr, 64'h18);
    chk("bc_valid", if_valid, 0);
    chk("bc_ifpc_kept", if_pc, 64'h10);
    chk("bc_req", imem_req, 1);
    branch = 1'b1;
    #1 chk("bnt_pcsrc", pc_src, 0);
    step();
    branch = 1'b0;
    chk("bnt_addr", imem_addr, 64'h1C);
    chk("bnt_ifpc", if_pc, 64'h18);
    chk("bnt_valid", if_valid, 1);

    // 4: unconditional branch with ready and stall together
    uncondbranch = 1'b1; branch_pc = 64'h40; branch_offset = 64'h10; id_stall = 1'b1;
    #1 chk("ub_pcsrc", pc_src, 1);
    step();
    uncondbranch = 1'b0; id_stall = 1'b0;
    chk("ub_addr", imem_addr, 64'h80);
    chk("ub_valid", if_valid, 0);
    chk("ub_ifpc_kept", if_pc, 64'h18);
    chk("ub_req", imem_req, 1);

    // 5: PC wrap on sequential fetch and on target add
    uncondbranch = 1'b1; branch_pc = 64'h0; branch_offset = 64'h3FFF_FFFF_FFFF_FFFF;
    step();
    uncondbranch = 1'b0;
    chk("wrap_addr0", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    chk("wrap_addr1", imem_addr, 64'h0);
    chk("wrap_ifpc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_valid", if_valid, 1);
    uncondbranch = 1'b1; branch_pc = 64'hFFFF_FFFF_FFFF_FFF0; branch_offset = 64'h8;
    step();
    uncondbranch = 1'b0;
    chk("twrap_addr", imem_addr, 64'h10);

    // 6: async reset in HOLD, late ready ignored in IDLE
    step();
    chk("pre_valid", if_valid, 1);
    chk("pre_ifpc", if_pc, 64'h10);
    id_stall = 1'b1;
    step();
    chk("pre_hold_req", imem_req, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", if_valid, 0);
    chk("ar_pc", if_pc, 0);
    chk("ar_instr", if_instr, 0);
    chk("ar_addr", imem_addr, 0);
    chk("ar_req", imem_req, 0);
    step();
    rst_n = 1'b1; id_stall = 1'b0;
    #1 chk("ar_idle_req", imem_req, 0);
    step();
    chk("rs_addr", imem_addr, 64'h0);
    chk("rs_valid", if_valid, 0);
    chk("rs_req", imem_req, 1);
    step();
    chk("rs_ifpc", if_pc, 64'h0);
    chk("rs_valid1", if_valid, 1);
    chk("rs_addr1", imem_addr, 64'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
